// File: rtl/debug_pkg.sv
// Shared definitions for the debug serial link (frame transmitter and receiver).
package debug_pkg;

   // One-hot frame receiver states; the encoding is visible on current_state.
   typedef enum logic [3:0] {
      StIdle    = 4'b0001,
      StCollect = 4'b0010,
      StTerm    = 4'b0100,
      StResync  = 4'b1000
   } frame_state_e;

   // Bit-level UART receiver states.
   typedef enum logic [1:0] {
      RxIdle,
      RxStart,
      RxData,
      RxStop
   } uart_rx_state_e;

   localparam logic [7:0] DEBUG_NEWLINE = 8'h0A;

   // 22 MHz clock / 191 ticks per bit ~= 115200 baud.
   localparam int unsigned DEBUG_UART_TICKS_PER_BIT      = 191;
   localparam int unsigned DEBUG_UART_TICKS_PER_BIT_SIZE = 8;

endpackage

// File: rtl/debug_uart_rx.sv
// UART byte receiver: 8N1, LSB first, one-cycle o_recvdata pulse per good byte.
module debug_uart_rx
   import debug_pkg::*;
#(
   parameter int unsigned TICKS_PER_BIT      = DEBUG_UART_TICKS_PER_BIT,
   parameter int unsigned TICKS_PER_BIT_SIZE = DEBUG_UART_TICKS_PER_BIT_SIZE
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       i_enable,
   input  logic       i_rx,
   output logic [7:0] o_rxdata,
   output logic       o_recvdata,
   output logic       o_busy
);

   localparam logic [TICKS_PER_BIT_SIZE-1:0] LastTick =
      TICKS_PER_BIT_SIZE'(TICKS_PER_BIT - 1);
   // Re-check the start bit half a bit later so data bits are sampled mid-bit.
   localparam logic [TICKS_PER_BIT_SIZE-1:0] HalfTick =
      TICKS_PER_BIT_SIZE'(TICKS_PER_BIT / 2 - 1);

   uart_rx_state_e                state_q, state_d;
   logic [TICKS_PER_BIT_SIZE-1:0] tick_q, tick_d;
   logic [2:0]                    bit_q, bit_d;
   logic [7:0]                    data_q, data_d;
   logic                          recv_q, recv_d;
   logic                          rx_meta_q, rx_sync_q;

   // Two-flop synchroniser for the asynchronous serial line (idles high).
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= i_rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   // Receiver state and datapath registers.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q <= RxIdle;
         tick_q  <= '0;
         bit_q   <= '0;
         data_q  <= '0;
         recv_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         recv_q  <= recv_d;
      end
   end

   // Bit timing: start detect, mid-bit sampling, stop-bit validation.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      data_d  = data_q;
      recv_d  = 1'b0;
      unique case (state_q)
         RxIdle: begin
            tick_d = '0;
            bit_d  = '0;
            if (i_enable && !rx_sync_q) state_d = RxStart;
         end
         RxStart: begin
            if (tick_q == HalfTick) begin
               tick_d  = '0;
               // A glitch shorter than half a bit is not a start bit.
               state_d = rx_sync_q ? RxIdle : RxData;
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         RxData: begin
            if (tick_q == LastTick) begin
               tick_d = '0;
               data_d = {rx_sync_q, data_q[7:1]};
               bit_d  = bit_q + 1'b1;
               if (bit_q == 3'd7) state_d = RxStop;
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         RxStop: begin
            if (tick_q == LastTick) begin
               tick_d  = '0;
               state_d = RxIdle;
               recv_d  = rx_sync_q;
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         default: state_d = RxIdle;
      endcase
   end

   assign o_rxdata   = data_q;
   assign o_recvdata = recv_q;
   assign o_busy     = (state_q != RxIdle);

endmodule

// File: rtl/debug_frame_rx.sv
// Debug link receiver: assembles newline-terminated frames into parallel words.
module debug_frame_rx
   import debug_pkg::*;
#(
   parameter int unsigned                   DATA_WIDTH              = 8,
   parameter int unsigned                   DATA_WIDTH_BASE2        = 4,
   parameter int unsigned                   UART_TICKS_PER_BIT      = DEBUG_UART_TICKS_PER_BIT,
   parameter int unsigned                   UART_TICKS_PER_BIT_SIZE = DEBUG_UART_TICKS_PER_BIT_SIZE,
   parameter int unsigned                   TIMEOUT_TICKS_WIDTH     = 24,
   parameter logic [TIMEOUT_TICKS_WIDTH-1:0] TIMEOUT_TICKS          = 24'd2200000
) (
   input  logic                  clk_in,
   input  logic                  reset,
   input  logic                  uart_rx_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  frame_error,
   output logic [15:0]           frame_count,
   output logic [3:0]            current_state,
   output logic                  busy
);

   localparam int unsigned NBytes = DATA_WIDTH / 8;
   localparam int unsigned RemW   = DATA_WIDTH_BASE2 + 1;
   localparam logic [RemW-1:0] RemStart = RemW'(NBytes - 1);
   localparam logic [RemW-1:0] RemOne   = RemW'(1);

   logic [7:0] rx_byte;
   logic       rx_recv;

   debug_uart_rx #(
      .TICKS_PER_BIT      (UART_TICKS_PER_BIT),
      .TICKS_PER_BIT_SIZE (UART_TICKS_PER_BIT_SIZE)
   ) u_uart_rx (
      .clk_in     (clk_in),
      .reset      (reset),
      .i_enable   (1'b1),
      .i_rx       (uart_rx_in),
      .o_rxdata   (rx_byte),
      .o_recvdata (rx_recv),
      .o_busy     ()
   );

   frame_state_e                   state_q, state_d;
   logic [DATA_WIDTH-1:0]          shift_q, shift_d;
   logic [RemW-1:0]                remaining_q, remaining_d;
   logic [TIMEOUT_TICKS_WIDTH-1:0] timeout_q, timeout_d;
   logic [DATA_WIDTH-1:0]          data_q, data_d;
   logic [15:0]                    frame_count_q, frame_count_d;
   logic                           valid_q, valid_d;
   logic                           error_q, error_d;
   logic                           timeout_hit;
   logic [DATA_WIDTH-1:0]          shift_in;

   // Frame FSM, timeout counter and registered outputs.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         shift_q       <= '0;
         remaining_q   <= '0;
         timeout_q     <= '0;
         data_q        <= '0;
         frame_count_q <= '0;
         valid_q       <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         shift_q       <= shift_d;
         remaining_q   <= remaining_d;
         timeout_q     <= timeout_d;
         data_q        <= data_d;
         frame_count_q <= frame_count_d;
         valid_q       <= valid_d;
         error_q       <= error_d;
      end
   end

   // Next state: positional framing, terminator check, timeout and resync.
   always_comb begin
      state_d       = state_q;
      shift_d       = shift_q;
      remaining_d   = remaining_q;
      data_d        = data_q;
      frame_count_d = frame_count_q;
      valid_d       = 1'b0;
      error_d       = 1'b0;
      // Shift form also covers the single-byte frame without slicing out of range.
      shift_in      = (shift_q << 8) | DATA_WIDTH'(rx_byte);
      timeout_hit   = (timeout_q == TIMEOUT_TICKS);

      // Byte events take priority over a coincident timeout.
      if (state_q == StIdle || rx_recv || timeout_hit) timeout_d = '0;
      else                                             timeout_d = timeout_q + 1'b1;

      unique case (state_q)
         StIdle: begin
            if (rx_recv) begin
               shift_d     = shift_in;
               remaining_d = RemStart;
               state_d     = (NBytes == 1) ? StTerm : StCollect;
            end
         end
         StCollect: begin
            if (rx_recv) begin
               shift_d     = shift_in;
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == RemOne) state_d = StTerm;
            end else if (timeout_hit) begin
               error_d = 1'b1;
               state_d = StIdle;
            end
         end
         StTerm: begin
            if (rx_recv) begin
               if (rx_byte == DEBUG_NEWLINE) begin
                  data_d        = shift_q;
                  valid_d       = 1'b1;
                  frame_count_d = frame_count_q + 1'b1;
                  state_d       = StIdle;
               end else begin
                  error_d = 1'b1;
                  state_d = StResync;
               end
            end else if (timeout_hit) begin
               error_d = 1'b1;
               state_d = StIdle;
            end
         end
         StResync: begin
            if (rx_recv) begin
               if (rx_byte == DEBUG_NEWLINE) state_d = StIdle;
            end else if (timeout_hit) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign data_out      = data_q;
   assign data_valid    = valid_q;
   assign frame_error   = error_q;
   assign frame_count   = frame_count_q;
   assign current_state = state_q;
   assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_debug_frame_rx.sv
// Directed bench for debug_frame_rx: serial byte driver and immediate assertions.
module tb_debug_frame_rx;

   localparam int unsigned DW      = 16;
   localparam int unsigned Ticks   = 32;
   localparam int unsigned Timeout = 1000;

   logic          clk_in = 1'b0;
   logic          reset;
   logic          uart_rx_in;
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic          frame_error;
   logic [15:0]   frame_count;
   logic [3:0]    current_state;
   logic          busy;

   int checks = 0;
   int fails  = 0;

   // Pulse monitor counters, written only by the monitor process.
   int vcnt = 0, ecnt = 0, overlap = 0, long_pulse = 0, spurious = 0;
   logic          prev_valid = 1'b0, prev_error = 1'b0;
   logic [DW-1:0] prev_data = '0;
   int v0, e0;

   debug_frame_rx #(
      .DATA_WIDTH              (DW),
      .DATA_WIDTH_BASE2        (4),
      .UART_TICKS_PER_BIT      (Ticks),
      .UART_TICKS_PER_BIT_SIZE (8),
      .TIMEOUT_TICKS_WIDTH     (24),
      .TIMEOUT_TICKS           (24'(Timeout))
   ) dut (
      .clk_in        (clk_in),
      .reset         (reset),
      .uart_rx_in    (uart_rx_in),
      .data_out      (data_out),
      .data_valid    (data_valid),
      .frame_error   (frame_error),
      .frame_count   (frame_count),
      .current_state (current_state),
      .busy          (busy)
   );

   always #5 clk_in = ~clk_in;

   // Count pulses and catch malformed ones, sampled on the falling edge.
   always @(negedge clk_in) begin
      if (!reset) begin
         if (data_valid) vcnt <= vcnt + 1;
         if (frame_error) ecnt <= ecnt + 1;
         if (data_valid && frame_error) overlap <= overlap + 1;
         if ((data_valid && prev_valid) || (frame_error && prev_error))
            long_pulse <= long_pulse + 1;
         if ((data_out !== prev_data) && !data_valid) spurious <= spurious + 1;
      end
      prev_valid <= data_valid;
      prev_error <= frame_error;
      prev_data  <= data_out;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      uart_rx_in = 1'b0;
      repeat (Ticks) @(negedge clk_in);
      for (int i = 0; i < 8; i++) begin
         uart_rx_in = b[i];
         repeat (Ticks) @(negedge clk_in);
      end
      uart_rx_in = 1'b1;
      repeat (Ticks + 4) @(negedge clk_in);
   endtask

   task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      send_byte(b0);
      send_byte(b1);
      send_byte(b2);
      repeat (3) @(negedge clk_in);
   endtask

   task automatic mark();
      v0 = vcnt;
      e0 = ecnt;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " data_out"}, 32'(data_out), 32'h0);
      check({tag, " data_valid"}, 32'(data_valid), 32'h0);
      check({tag, " frame_error"}, 32'(frame_error), 32'h0);
      check({tag, " frame_count"}, 32'(frame_count), 32'h0);
      check({tag, " state"}, 32'(current_state), 32'h1);
      check({tag, " busy"}, 32'(busy), 32'h0);
   endtask

   initial begin
      reset      = 1'b1;
      uart_rx_in = 1'b1;
      repeat (4) @(negedge clk_in);
      check_reset_values("reset");
      reset = 1'b0;
      repeat (4) @(negedge clk_in);

      // Good frame.
      mark();
      send_frame(8'hBE, 8'hEF, 8'h0A);
      check("good data", 32'(data_out), 32'hBEEF);
      check("good valid pulses", 32'(vcnt - v0), 32'd1);
      check("good error pulses", 32'(ecnt - e0), 32'd0);
      check("good count", 32'(frame_count), 32'd1);
      check("good state", 32'(current_state), 32'h1);
      check("good busy", 32'(busy), 32'h0);

      // Bad terminator, resync, then recovery.
      mark();
      send_frame(8'h12, 8'h34, 8'h55);
      check("bad error pulses", 32'(ecnt - e0), 32'd1);
      check("bad valid pulses", 32'(vcnt - v0), 32'd0);
      check("bad state", 32'(current_state), 32'h8);
      check("bad busy", 32'(busy), 32'h1);
      send_byte(8'h99);
      check("resync ignore state", 32'(current_state), 32'h8);
      check("resync no extra error", 32'(ecnt - e0), 32'd1);
      send_byte(8'h0A);
      check("resync idle", 32'(current_state), 32'h1);
      check("resync held data", 32'(data_out), 32'hBEEF);
      check("resync held count", 32'(frame_count), 32'd1);
      mark();
      send_frame(8'h01, 8'h02, 8'h0A);
      check("recover data", 32'(data_out), 32'h0102);
      check("recover count", 32'(frame_count), 32'd2);
      check("recover valid pulses", 32'(vcnt - v0), 32'd1);
      check("recover error pulses", 32'(ecnt - e0), 32'd0);

      // Newlines inside the payload are ordinary data.
      send_frame(8'h0A, 8'h0A, 8'h0A);
      check("embedded data", 32'(data_out), 32'h0A0A);
      check("embedded count", 32'(frame_count), 32'd3);
      check("embedded state", 32'(current_state), 32'h1);

      // Inter-byte timeout in COLLECT.
      mark();
      send_byte(8'h12);
      check("timeout collect", 32'(current_state), 32'h2);
      repeat (Timeout - 40) @(negedge clk_in);
      check("timeout not early", 32'(ecnt - e0), 32'd0);
      check("timeout still collect", 32'(current_state), 32'h2);
      repeat (60) @(negedge clk_in);
      check("timeout error pulses", 32'(ecnt - e0), 32'd1);
      check("timeout idle", 32'(current_state), 32'h1);
      send_frame(8'hAB, 8'hCD, 8'h0A);
      check("after timeout data", 32'(data_out), 32'hABCD);
      check("after timeout count", 32'(frame_count), 32'd4);

      // Reset in the middle of a frame.
      send_byte(8'hAA);
      check("midreset collect", 32'(current_state), 32'h2);
      reset = 1'b1;
      repeat (3) @(negedge clk_in);
      check_reset_values("midreset");
      reset = 1'b0;
      repeat (4) @(negedge clk_in);
      send_frame(8'h11, 8'h22, 8'h0A);
      check("midreset data", 32'(data_out), 32'h1122);
      check("midreset count", 32'(frame_count), 32'd1);

      // Frame counter wraps.
      force dut.frame_count_q = 16'hFFFF;
      @(negedge clk_in);
      release dut.frame_count_q;
      @(negedge clk_in);
      check("wrap preset", 32'(frame_count), 32'hFFFF);
      send_frame(8'h5A, 8'hA5, 8'h0A);
      check("wrap count", 32'(frame_count), 32'h0);
      check("wrap data", 32'(data_out), 32'h5AA5);

      check("pulse overlap", 32'(overlap), 32'd0);
      check("pulse width", 32'(long_pulse), 32'd0);
      check("data_out change without valid", 32'(spurious), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
